// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg : shared types and forward encodings for the hazard controller
// Revision: 1.0
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // Field layout (msb..lsb): valid[7], rd[6:2], we[1], is_load[0]
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       is_load;
   } sb_entry_t;

   localparam int SB_W = $bits(sb_entry_t);

   localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: 5'd0, we: 1'b0, is_load: 1'b0};

   function automatic logic sb_match(input sb_entry_t e, input logic [4:0] src, input logic re);
      return e.valid & e.we & (e.rd != 5'd0) & (e.rd == src) & re;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_fwd_match : priority matcher of one source register against EX/MEM/WB
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_fwd_match
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0]      src,
   input  logic            re,
   input  logic [SB_W-1:0] ex_entry,
   input  logic [SB_W-1:0] mem_entry,
   input  logic [SB_W-1:0] wb_entry,
   output logic [1:0]      sel,
   output logic            ex_load_hit
);

   sb_entry_t ex_e;
   sb_entry_t mem_e;
   sb_entry_t wb_e;
   logic      ex_hit;
   logic      mem_hit;
   logic      wb_hit;
   logic      unused_load_bits;

   always_comb begin
      ex_e    = sb_entry_t'(ex_entry);
      mem_e   = sb_entry_t'(mem_entry);
      wb_e    = sb_entry_t'(wb_entry);
      ex_hit  = sb_match(ex_e, src, re);
      mem_hit = sb_match(mem_e, src, re);
      wb_hit  = sb_match(wb_e, src, re);

      // Youngest producer wins
      sel = FWD_RF;
      if (ex_hit)       sel = FWD_EX;
      else if (mem_hit) sel = FWD_MEM;
      else if (wb_hit)  sel = FWD_WB;

      ex_load_hit = ex_hit & ex_e.is_load;
   end

   assign unused_load_bits = mem_e.is_load ^ wb_e.is_load;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : EX/MEM/WB scoreboard, operand forwarding, load-use stall, redirect flush
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_re1,
   input  logic             id_re2,
   input  logic [4:0]       id_rd,
   input  logic             id_rf_we,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   sb_entry_t        ex_q, ex_d;
   sb_entry_t        mem_q, mem_d;
   sb_entry_t        wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [1:0]       sel_a;
   logic [1:0]       sel_b;
   logic             ld_hit_a;
   logic             ld_hit_b;
   logic             load_use;
   logic             stall_hit;
   logic             issue;

   hazard_fwd_match u_match_a (
      .src         (id_rs1),
      .re          (id_re1),
      .ex_entry    (ex_q),
      .mem_entry   (mem_q),
      .wb_entry    (wb_q),
      .sel         (sel_a),
      .ex_load_hit (ld_hit_a)
   );

   hazard_fwd_match u_match_b (
      .src         (id_rs2),
      .re          (id_re2),
      .ex_entry    (ex_q),
      .mem_entry   (mem_q),
      .wb_entry    (wb_q),
      .sel         (sel_b),
      .ex_load_hit (ld_hit_b)
   );

   always_comb begin
      load_use  = id_valid & (ld_hit_a | ld_hit_b);
      // A redirect makes the stalled instruction wrong-path, so it wins
      stall_hit = load_use & ~ex_redirect;
      issue     = id_valid & ~load_use & ~ex_redirect;

      fwd_a_sel  = sel_a;
      fwd_b_sel  = sel_b;
      stall_pc   = stall_hit;
      stall_ifid = stall_hit;
      flush_ifid = ex_redirect;
      flush_idex = load_use | ex_redirect;

      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = SB_BUBBLE;
      if (issue) begin
         ex_d = '{valid: 1'b1, rd: id_rd, we: id_rf_we, is_load: id_is_load};
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_hit && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      flush_cnt_d = flush_cnt_q;
      if (ex_redirect && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= SB_BUBBLE;
         mem_q       <= SB_BUBBLE;
         wb_q        <= SB_BUBBLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : scoreboard-driven bench for hazard_ctrl (32-bit and 4-bit counters)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       re1;
      logic       re2;
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic       redir;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_re1, id_re2, id_rf_we, id_is_load, ex_redirect;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel4, fwd_b_sel4;
   logic        stall_pc, stall_ifid, flush_ifid, flush_idex;
   logic        stall_pc4, stall_ifid4, flush_ifid4, flush_idex4;
   logic [31:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt4, flush_cnt4;
   logic [7:0]  obs, obs4;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_stall = 0;
   logic [31:0] m_flush = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_rf_we(id_rf_we),
      .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_pc(stall_pc),
      .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_rf_we(id_rf_we),
      .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4), .stall_pc(stall_pc4),
      .stall_ifid(stall_ifid4), .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   // Observed bits: {fwd_a[1:0], fwd_b[1:0], stall_pc, stall_ifid, flush_ifid, flush_idex}
   assign obs  = {fwd_a_sel, fwd_b_sel, stall_pc, stall_ifid, flush_ifid, flush_idex};
   assign obs4 = {fwd_a_sel4, fwd_b_sel4, stall_pc4, stall_ifid4, flush_ifid4, flush_idex4};

   function automatic stim_t idle();
      return '0;
   endfunction

   function automatic stim_t op(input logic [4:0] rd, rs1, rs2, input logic re2, ld, redir);
      stim_t s;
      s = '0;
      s.v = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.re1 = 1'b1; s.re2 = re2;
      s.we = 1'b1; s.ld = ld; s.redir = redir;
      return s;
   endfunction

   function automatic stim_t lw(input logic [4:0] rd, rs1);
      return op(rd, rs1, 5'd0, 1'b0, 1'b1, 1'b0);
   endfunction

   function automatic stim_t alu(input logic [4:0] rd, rs1, rs2);
      return op(rd, rs1, rs2, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic logic [3:0] sat4(input logic [31:0] v);
      return (v > 32'd15) ? 4'd15 : v[3:0];
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst; id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2; id_re1 = s.re1;
      id_re2 = s.re2; id_rd = s.rd; id_rf_we = s.we; id_is_load = s.ld; ex_redirect = s.redir;
   endtask

   // Counter model: advanced from the bench's own expectation of each cycle
   task automatic model_edge(input logic r, input logic [7:0] e);
      if (e[3]) m_stall = m_stall + 1;
      if (e[1]) m_flush = m_flush + 1;
      if (r) begin m_stall = 0; m_flush = 0; end
   endtask

   task automatic test_reset();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e; stim_t s;
      s = lw(5'd5, 5'd0); s.rst = 1'b1;
      st.push_back(s);                  ev.push_back(8'b00_00_0000);
      st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(8'b00_00_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL reset row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
         errors++; $display("FAIL reset_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
      end
   endtask

   task automatic test_forward_ex();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e;
      st.push_back(alu(5'd1, 5'd2, 5'd3)); ev.push_back(8'b00_00_0000);
      st.push_back(alu(5'd4, 5'd1, 5'd5)); ev.push_back(8'b01_00_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL fwd_ex row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e;
      st.push_back(lw(5'd5, 5'd0));        ev.push_back(8'b00_00_0000);
      st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(8'b01_01_1101);
      st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(8'b10_10_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL load_use row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush || stall_cnt !== 32'd1) begin
         errors++; $display("FAIL load_use_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
      end
   endtask

   task automatic test_distance();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e; logic [4:0] r; logic [1:0] sel;
      for (int n = 0; n < 2; n++) begin
         r = (n == 0) ? 5'd7 : 5'd0;
         for (int d = 1; d <= 3; d++) begin
            st.push_back(op(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0)); ev.push_back(8'h00);
            for (int k = 1; k < d; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
            sel = (r == 5'd0) ? 2'b00 : (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b11;
            st.push_back(alu(5'd8, r, 5'd0)); ev.push_back({sel, 6'b00_0000});
            for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
         end
      end
      st.push_back(lw(5'd0, 5'd0));        ev.push_back(8'h00);
      st.push_back(alu(5'd8, 5'd0, 5'd0)); ev.push_back(8'h00);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL distance row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e; stim_t s;
      s = alu(5'd6, 5'd5, 5'd5); s.redir = 1'b1;
      st.push_back(lw(5'd5, 5'd0));        ev.push_back(8'b00_00_0000);
      st.push_back(s);                     ev.push_back(8'b01_01_0011);
      st.push_back(alu(5'd9, 5'd6, 5'd5)); ev.push_back(8'b00_10_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL redirect row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush || flush_cnt4 !== sat4(m_flush)) begin
         errors++; $display("FAIL redirect_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e;
      st.push_back(lw(5'd5, 5'd0));        ev.push_back(8'b00_00_0000);
      st.push_back(lw(5'd6, 5'd5));        ev.push_back(8'b01_00_1101);
      st.push_back(lw(5'd6, 5'd5));        ev.push_back(8'b10_00_0000);
      st.push_back(alu(5'd7, 5'd6, 5'd0)); ev.push_back(8'b01_00_1101);
      st.push_back(alu(5'd7, 5'd6, 5'd0)); ev.push_back(8'b10_00_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL back_to_back row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e; stim_t s;
      s = alu(5'd6, 5'd5, 5'd5); s.rst = 1'b1;
      st.push_back(lw(5'd5, 5'd0));        ev.push_back(8'b00_00_0000);
      st.push_back(s);                     ev.push_back(8'b01_01_1101);
      st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(8'b00_00_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL reset_mid_stall row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_cnt4 !== 4'd0 || flush_cnt4 !== 4'd0) begin
         errors++; $display("FAIL reset_mid_stall_cnt: got %0d/%0d/%0d/%0d want 0/0/0/0", stall_cnt, flush_cnt, stall_cnt4, flush_cnt4);
      end
   endtask

   task automatic test_saturate();
      stim_t st[$]; logic [7:0] ev[$]; logic [7:0] e; stim_t s;
      s = idle(); s.rst = 1'b1;
      st.push_back(s); ev.push_back(8'h00);
      for (int k = 0; k < 20; k++) begin
         st.push_back(lw(5'd5, 5'd0));        ev.push_back(8'b00_00_0000);
         st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(8'b01_01_1101);
      end
      st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(8'b10_10_0000);
      for (int k = 0; k < 3; k++) begin st.push_back(idle()); ev.push_back(8'h00); end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]); exp_q.push_back(ev[i]);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (obs !== e || obs4 !== e) begin
            errors++; $display("FAIL saturate row %0d: got %b / %b want %b", i, obs, obs4, e);
         end
         model_edge(st[i].rst, e);
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cnt4 !== 4'd15 || stall_cnt4 !== sat4(m_stall)) begin
         errors++; $display("FAIL saturate_cnt4: got %0d want 15", stall_cnt4);
      end
      checks++;
      if (stall_cnt !== m_stall || stall_cnt !== 32'd20) begin
         errors++; $display("FAIL saturate_cnt32: got %0d want %0d", stall_cnt, m_stall);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      apply(idle());
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_forward_ex();
      test_load_use();
      test_distance();
      test_redirect();
      test_back_to_back();
      test_reset_mid_stall();
      test_saturate();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
